// File: rtl/i2s_tx_param.sv
// I2S transmitter with a stereo-pair FIFO, programmable slot/sample width and
// bit-clock divider. Frames are loaded from the FIFO at the start of each left slot.
module i2s_tx_param #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int DEPTH    = 4,
  parameter int SCLK_DIV = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic                   mono,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_left,
  input  logic [DATA_W-1:0]      in_right,
  output logic                   in_ready,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   sclk,
  output logic                   lrclk,
  output logic                   sdout,
  output logic                   underrun
);

  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = AW + 1;
  localparam int FRAME = 2 * SLOT_W;
  localparam int PW    = $clog2(FRAME);
  localparam int DVW   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  if (DATA_W > SLOT_W) begin : g_bad_data_w
    $error("i2s_tx_param: DATA_W (%0d) must not exceed SLOT_W (%0d)", DATA_W, SLOT_W);
  end
  if (SCLK_DIV < 1) begin : g_bad_sclk_div
    $error("i2s_tx_param: SCLK_DIV (%0d) must be at least 1", SCLK_DIV);
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("i2s_tx_param: DEPTH (%0d) must be a power of 2 and at least 2", DEPTH);
  end

  // Left-justify a sample inside its slot; the unused LSBs go out as zeros.
  function automatic logic [SLOT_W-1:0] to_slot(input logic [DATA_W-1:0] s);
    return SLOT_W'(s) << (SLOT_W - DATA_W);
  endfunction

  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [FW-1:0]       fill_next;
  logic                push;
  logic                pop;

  logic [DVW-1:0]      div;
  logic [PW-1:0]       pos;
  logic [PW-1:0]       pos_next;
  logic [FRAME-1:0]    shreg;
  logic [FRAME-1:0]    frame_word;
  logic [2*DATA_W-1:0] head;
  logic [DATA_W-1:0]   head_l;
  logic [DATA_W-1:0]   head_r;
  logic                tick;
  logic                fall;
  logic                load;
  logic                lr_next;

  assign push = in_valid && in_ready;
  assign pop  = load && (fill != '0);

  always_comb begin
    fill_next = fill;
    if (push && !pop) begin
      fill_next = fill + 1'b1;
    end else if (pop && !push) begin
      fill_next = fill - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_left, in_right};
    end
  end

  // in_ready is registered from the next occupancy so a pop never reaches it combinationally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      fill     <= fill_next;
      in_ready <= (fill_next < FW'(DEPTH));
    end
  end

  assign head       = mem[rd_ptr];
  assign head_l     = head[2*DATA_W-1 -: DATA_W];
  assign head_r     = head[DATA_W-1:0];
  assign frame_word = (fill != '0) ? {to_slot(head_l), to_slot(mono ? head_l : head_r)} : '0;

  assign tick     = (div == DVW'(SCLK_DIV - 1));
  assign fall     = en && tick && sclk;
  assign pos_next = (pos == PW'(FRAME - 1)) ? '0 : pos + 1'b1;
  assign load     = fall && (pos_next == '0);
  // Word select switches one bit ahead of the slot it announces.
  assign lr_next  = (pos_next >= PW'(SLOT_W - 1)) && (pos_next <= PW'(FRAME - 2));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div      <= '0;
      sclk     <= 1'b0;
      pos      <= PW'(FRAME - 1);
      lrclk    <= 1'b0;
      sdout    <= 1'b0;
      underrun <= 1'b0;
      shreg    <= '0;
    end else if (!en) begin
      div      <= '0;
      sclk     <= 1'b0;
      pos      <= PW'(FRAME - 1);
      lrclk    <= 1'b0;
      sdout    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= load && (fill == '0);
      if (tick) begin
        div  <= '0;
        sclk <= ~sclk;
      end else begin
        div <= div + 1'b1;
      end
      if (fall) begin
        pos   <= pos_next;
        lrclk <= lr_next;
        if (load) begin
          sdout <= frame_word[FRAME-1];
          shreg <= frame_word << 1;
        end else begin
          sdout <= shreg[FRAME-1];
          shreg <= shreg << 1;
        end
      end
    end
  end

endmodule

// File: doc/i2s_tx_param.md
I2S_TX_PARAM -- requirements
Module: i2s_tx_param

Interface
REQ-001 SHALL have parameter DATA_W, default 24, sample width in bits.
REQ-002 SHALL have parameter SLOT_W, default 32, sclk periods per channel slot.
REQ-003 SHALL have parameter DEPTH, default 4, FIFO depth in stereo pairs.
REQ-004 SHALL have parameter SCLK_DIV, default 2, clk cycles per sclk half-period.
REQ-005 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-006 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port en  input  1  serializer enable.
REQ-008 SHALL have port mono  input  1  1 = left sample sent in both slots.
REQ-009 SHALL have port in_valid  input  1  sample pair valid.
REQ-010 SHALL have port in_left  input  DATA_W  left sample, two's complement.
REQ-011 SHALL have port in_right  input  DATA_W  right sample, ignored when mono=1.
REQ-012 SHALL have port in_ready  output  1  FIFO can accept a pair.
REQ-013 SHALL have port fill  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-014 SHALL have port sclk  output  1  I2S bit clock.
REQ-015 SHALL have port lrclk  output  1  I2S word select, 0 = left.
REQ-016 SHALL have port sdout  output  1  I2S serial data.
REQ-017 SHALL have port underrun  output  1  one-clk pulse when a frame starts with FIFO empty.

Function
REQ-018 SHALL reject at elaboration: DATA_W > SLOT_W, SCLK_DIV < 1, DEPTH not a power of 2 or < 2.
REQ-019 SHALL push {in_left,in_right} on a clk edge with in_valid=1 and in_ready=1; in_ready = (fill < DEPTH), registered, no combinational path from pop.
REQ-020 SHALL, on simultaneous push and pop, leave fill unchanged; full FIFO SHALL not accept a push even when popping that cycle.
REQ-021 SHALL toggle sclk every SCLK_DIV clk cycles while en=1; a sclk falling-edge event is the clk cycle where sclk goes 1->0.
REQ-022 SHALL keep frame position p (0..2*SLOT_W-1), advanced by 1 with wrap on each falling-edge event; p=0 = left MSB, p=SLOT_W = right MSB.
REQ-023 SHALL drive lrclk = 1 for p in [SLOT_W-1, 2*SLOT_W-2], else 0 (word select leads data by one bit).
REQ-024 SHALL drive sdout = sample bit (DATA_W-1-k) at slot offset k < DATA_W, 0 for DATA_W <= k < SLOT_W; sdout and lrclk change only on falling-edge events.
REQ-025 SHALL, on the falling-edge event entering p=0, pop FIFO head into the output shift register; if FIFO empty, load all-zero frame and pulse underrun for exactly one clk.
REQ-026 SHALL, with mono=1 at load time, transmit the left sample in both slots; mono changes take effect only at the next load.
REQ-027 SHALL, when en=0, hold sclk=0, lrclk=0, sdout=0, divider=0, p=2*SLOT_W-1; FIFO contents and push side remain operational.
REQ-028 SHALL, after en 0->1, produce first falling edge at 2*SCLK_DIV clk cycles, entering p=0 and loading a frame.
REQ-029 SHALL, on en 1->0 mid-frame, abandon the current frame (no pop, not resumed).

Reset
REQ-030 SHALL, while rstn=0, force sclk=0, lrclk=0, sdout=0, underrun=0, fill=0, in_ready=0, divider=0, p=2*SLOT_W-1, shift register=0.
REQ-031 SHALL assert in_ready=1 on the first clk edge after rstn deasserts; reset mid-frame SHALL empty the FIFO and discard the frame.

Verification
REQ-032 SHALL cover: rstn low 250 ns -> all outputs 0, fill=0; first edge after release -> in_ready=1.
REQ-033 SHALL cover: defaults, push L=AAAAAA R=555555, en=1 -> left slot 1010..10 + 8 zeros, right slot 0101..01 + 8 zeros, lrclk rises at p=31, falls at p=63, sclk period 4 clk.
REQ-034 SHALL cover: 5 pushes, en=0 -> fill=4, in_ready=0 after 4th, 5th pair dropped; then en=1 -> 4 frames in push order, no underrun.
REQ-035 SHALL cover: mono=1, push L=696969 R=FFFFFF -> both slots carry 696969 + 8 zeros.
REQ-036 SHALL cover: en=1 with empty FIFO -> zero frames, underrun exactly one pulse per frame (every 256 clk); push mid-frame -> sent next frame.
REQ-037 SHALL cover: rstn asserted at p=40 with fill=2 -> outputs reset immediately, fill=0, frame discarded.
